// File: rtl/uart_byte_tx.sv
// uart_byte_tx: buffered 8N1 UART transmitter, FIFO-fed, bit period 16*max(divisor,1) clocks.
// Define UART_BYTE_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_byte_tx #(
    parameter int FIFO_AW = 4,
    parameter int DIV_W   = 16
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic [DIV_W-1:0]   divisor_i,
    input  logic [7:0]         tx_data_i,
    input  logic               tx_wr_i,
    output logic               tx_ready_o,
    output logic [FIFO_AW:0]   fifo_level_o,
    output logic               busy_o,
    output logic               tx_done_o,
    output logic               tx_o
);
`ifdef UART_BYTE_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [DIV_W+3:0] ONE = 1;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   level_q, level_d;
    state_t             state_q;
    logic [DIV_W+3:0]   cnt_q, per_q, per_d;
    logic [DIV_W-1:0]   dm1;
    logic [2:0]         idx_q;
    logic [7:0]         sh_q;
    logic               tx_q, done_q, wr, pop, last, empty;
    assign tx_ready_o   = !level_q[FIFO_AW];
    assign empty        = level_q == '0;
    assign wr           = tx_wr_i & tx_ready_o;
    assign last         = cnt_q == '0;
    assign pop          = !empty && (state_q == IDLE || (state_q == STOP && last));
    assign level_d      = level_q + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
    // cnt_q counts down from P-1, so the reload value is {max(div,1)-1, 4'hF}
    assign dm1          = divisor_i == '0 ? '0 : divisor_i - DIV_W'(1);
    assign per_d        = {dm1, 4'hF};
    assign fifo_level_o = level_q;
    assign busy_o       = state_q != IDLE;
    assign tx_done_o    = done_q;
    assign tx_o         = tx_q;
    always_ff @(posedge wb_clk_i) begin
        if (wr) mem_q[wptr_q] <= tx_data_i;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            per_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            level_q <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            level_q <= level_d;
            wptr_q  <= wr ? wptr_q + FIFO_AW'(1) : wptr_q;
            rptr_q  <= pop ? rptr_q + FIFO_AW'(1) : rptr_q;
            done_q  <= state_q == STOP && cnt_q == ONE;
            if (pop) begin
                sh_q    <= mem_q[rptr_q];
                per_q   <= per_d;
                cnt_q   <= per_d;
                tx_q    <= 1'b0;
                state_q <= START;
            end else if (state_q != IDLE) begin
                cnt_q <= last ? per_q : cnt_q - ONE;
                if (last) begin
                    case (state_q)
                        START: begin
                            idx_q   <= '0;
                            tx_q    <= sh_q[0];
                            state_q <= DATA;
                        end
                        DATA: begin
                            if (idx_q == 3'd7) begin
`ifdef UART_BYTE_TX_PARITY_EN
                                tx_q    <= ^sh_q;
                                state_q <= PARITY;
`else
                                tx_q    <= 1'b1;
                                state_q <= STOP;
`endif
                            end else begin
                                idx_q <= idx_q + 3'd1;
                                tx_q  <= sh_q[idx_q + 3'd1];
                            end
                        end
`ifdef UART_BYTE_TX_PARITY_EN
                        PARITY: begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end
`endif
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
- Buffered 8N1 UART transmitter for simulation and bring-up.
- Serialises bytes from a small FIFO onto a single line.
- Drives the SoC UART rx input, which is otherwise tied off. It is the sending counterpart of the simulation-side UART receiver that decodes the SoC UART tx line.
- Baud convention matches that receiver: divisor = f_clk / (16 × baud), so one bit period is 16 × divisor clocks.

Parameters:
- FIFO_AW, 4: FIFO address width. Depth = 2**FIFO_AW entries.
- DIV_W, 16: width of divisor_i and of the internal bit-period counter (counter is DIV_W+4 bits).

Ports:
- wb_clk_i  in  1: system clock. All logic is on the rising edge.
- wb_rst_i  in  1: reset. Synchronous, active-high.
- divisor_i  in  DIV_W: baud divisor. Sampled at each frame start. Value 0 is treated as 1.
- tx_data_i  in  8: byte to enqueue.
- tx_wr_i  in  1: enqueue strobe. Accepted only when tx_ready_o=1.
- tx_ready_o  out  1: FIFO not full.
- fifo_level_o  out  FIFO_AW+1: number of bytes queued. Excludes the byte currently being shifted.
- busy_o  out  1: a frame is in progress (state != IDLE).
- tx_done_o  out  1: single-cycle pulse on the last cycle of each stop bit.
- tx_o  out  1: serial line. Idle high.

Behaviour:
- Reset values (the cycle after wb_rst_i is sampled high): tx_o=1, busy_o=0, tx_done_o=0, fifo_level_o=0, tx_ready_o=1, state=IDLE, FIFO pointers 0.
- Reset mid-frame aborts immediately: the line returns high next cycle and queued bytes are discarded.
- FIFO:
  - A write is accepted when tx_wr_i & tx_ready_o. A write while full is silently dropped, even if a pop occurs in the same cycle.
  - A simultaneous accepted write and pop leaves the level unchanged.
  - Pointers wrap modulo depth. Full is level==2**FIFO_AW.
- FSM states: IDLE, START, DATA, STOP. Each bit period is P = 16 × max(divisor_i,1) clocks, latched into a register at the pop.
- IDLE:
  - If FIFO not empty: pop the head into shift register sh[7:0], latch P, tx_o<=0, go to START.
  - Otherwise tx_o=1.
- START: hold 0 for P cycles, then go to DATA with bit index 0 and tx_o<=sh[0].
- DATA:
  - Send LSB first, each bit held P cycles.
  - After bit 7 completes, tx_o<=1 and go to STOP.
- STOP:
  - Hold 1 for P cycles. On the last cycle assert tx_done_o.
  - Then, if FIFO not empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Latency: a byte written at edge N into an empty FIFO with IDLE state drives the start bit from edge N+1. A full frame is 10P cycles. tx_done_o is high in cycle N+10P.
- Changes to divisor_i mid-frame have no effect until the next pop.
- The bit counter is never observable outside the FSM. Line transitions occur only on bit-period boundaries.

Optional Feature:
- Macro: UART_BYTE_TX_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of the 8 data bits) is sent for P cycles between DATA and STOP, in an added state PARITY.
  - A frame is 11P cycles. tx_done_o moves accordingly.
- When undefined: no PARITY state and no parity logic; 10P-cycle 8N1 frames as above.

Test Plan:
- Reset, divisor_i=26, write 0x55 at edge N -> tx_o low for cycles N+1..N+416; then bits 1,0,1,0,1,0,1,0, each 416 cycles; stop high 416 cycles; tx_done_o=1 at exactly N+4160; busy_o=0 at N+4161.
- Loopback into the simulation UART receiver (divisor 26); write "Hi\n" (0x48,0x69,0x0A) back-to-back -> receiver rx_done three times with matching bytes; no idle gap between frames (stop of frame k is followed by start of frame k+1 on the next cycle).
- Hold the FSM on a slow divisor (0xFFFF); write 17 bytes 0x00..0x10 while the first frame is running -> first byte popped, fifo_level_o reaches 16, tx_ready_o=0; 18th write 0xAA dropped; transmitted sequence is 0x00..0x10, never 0xAA.
- divisor_i=0, write 0xF0 -> bit period 16 cycles; frame completes with tx_done_o at N+160.
- Assert wb_rst_i during DATA bit 3 with 5 bytes queued -> next cycle tx_o=1, busy_o=0, fifo_level_o=0; no further frames; a new write afterwards transmits normally.
- With UART_BYTE_TX_PARITY_EN and divisor 1, write 0x07 -> parity bit 1 sent for 16 cycles after bit 7; tx_done_o at N+176. Write 0x03 -> parity bit 0.
